mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter directly upstream of the RAM controller.
- Master 0 is the RISC-V core; master 1 is the PIM engine or DMA port.
- Each master uses the core-style strobe/busy protocol. The single slave port drives the RAM controller's core-side inputs.
- Requests are latched, arbitrated round-robin and issued to the slave one at a time. Read data is returned per master in a register.

---
 rtl/mem_bus_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master / one-slave arbiter in front of the RAM controller. Each master
//   (M0 = RISC-V core, M1 = PIM engine / DMA) uses the core-style strobe/busy
//   protocol. A request is latched into a per-master pending register,
//   arbitrated round-robin, and issued to the slave one at a time. Read data
//   is returned in a per-master register that holds until the next read.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mN_addr/wdata/wmask   request address, write data, byte write mask
//   mN_rstrb              read strobe (one-cycle pulse, wins over wmask)
//   mN_rdata              registered read data for master N
//   mN_rbusy / mN_wbusy   read / write outstanding for master N
//   s_addr/wdata/wmask    request to the RAM controller (zero when idle)
//   s_rstrb               read strobe to the RAM controller
//   s_rdata/rbusy/wbusy   response from the RAM controller
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUSY_WAIT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    input  logic                m0_rstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rbusy,
    output logic                m0_wbusy,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    input  logic                m1_rstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rbusy,
    output logic                m1_wbusy,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    output logic                s_rstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rbusy,
    input  logic                s_wbusy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(BUSY_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    // Master inputs gathered into arrays so both channels share one code path
    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_wdata [2];
    logic [MASK_W-1:0] in_wmask [2];
    logic [1:0]        in_rstrb;

    assign in_addr[0]  = m0_addr;
    assign in_addr[1]  = m1_addr;
    assign in_wdata[0] = m0_wdata;
    assign in_wdata[1] = m1_wdata;
    assign in_wmask[0] = m0_wmask;
    assign in_wmask[1] = m1_wmask;
    assign in_rstrb    = {m1_rstrb, m0_rstrb};

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        pend_v_q, pend_v_d;
    logic [1:0]        pend_rd_q, pend_rd_d;
    logic [ADDR_W-1:0] pend_addr_q  [2];
    logic [ADDR_W-1:0] pend_addr_d  [2];
    logic [DATA_W-1:0] pend_wdata_q [2];
    logic [DATA_W-1:0] pend_wdata_d [2];
    logic [MASK_W-1:0] pend_wmask_q [2];
    logic [MASK_W-1:0] pend_wmask_d [2];
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              seen_busy_q, seen_busy_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [MASK_W-1:0] s_wmask_q, s_wmask_d;
    logic              s_rstrb_q, s_rstrb_d;

    logic gnt;
    logic busy_in;
    logic done;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pend_v_d     = pend_v_q;
        pend_rd_d    = pend_rd_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_wmask_d = pend_wmask_q;
        rdata_d      = rdata_q;
        wait_cnt_d   = wait_cnt_q;
        seen_busy_d  = seen_busy_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wmask_d    = s_wmask_q;
        s_rstrb_d    = s_rstrb_q;
        busy_in      = s_rbusy | s_wbusy;
        done         = 1'b0;

        // On a tie the master not served last wins; otherwise the sole requester
        gnt = (&pend_v_q) ? ~last_grant_q : pend_v_q[1];

        // Capture: only one outstanding request per master, later strobes ignored
        for (int unsigned n = 0; n < 2; n++) begin
            if (!pend_v_q[n] && (in_rstrb[n] || (|in_wmask[n]))) begin
                pend_v_d[n]     = 1'b1;
                pend_rd_d[n]    = in_rstrb[n];
                pend_addr_d[n]  = in_addr[n];
                pend_wdata_d[n] = in_wdata[n];
                pend_wmask_d[n] = in_wmask[n];
            end
        end

        // Slave outputs are registered, so they are loaded on entry to each state
        case (state_q)
            IDLE: begin
                if (|pend_v_q) begin
                    grant_d   = gnt;
                    s_addr_d  = pend_addr_q[gnt];
                    s_wdata_d = pend_wdata_q[gnt];
                    s_rstrb_d = pend_rd_q[gnt];
                    s_wmask_d = pend_rd_q[gnt] ? '0 : pend_wmask_q[gnt];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                s_rstrb_d   = 1'b0;
                s_wmask_d   = '0;
                wait_cnt_d  = '0;
                seen_busy_d = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (busy_in) begin
                    seen_busy_d = 1'b1;
                end
                if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                // Timeout covers addresses the slave never services (e.g. IO 0xFFC)
                done = seen_busy_q ? !busy_in
                                   : (!busy_in && (wait_cnt_q >= CNT_LAST));
                if (done) begin
                    if (pend_rd_q[grant_q]) begin
                        rdata_d[grant_q] = s_rdata;
                    end
                    pend_v_d[grant_q] = 1'b0;
                    last_grant_d      = grant_q;
                    s_addr_d          = '0;
                    s_wdata_d         = '0;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pend_v_q     <= '0;
            pend_rd_q    <= '0;
            pend_addr_q  <= '{default: '0};
            pend_wdata_q <= '{default: '0};
            pend_wmask_q <= '{default: '0};
            rdata_q      <= '{default: '0};
            wait_cnt_q   <= '0;
            seen_busy_q  <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_wmask_q    <= '0;
            s_rstrb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pend_v_q     <= pend_v_d;
            pend_rd_q    <= pend_rd_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_wmask_q <= pend_wmask_d;
            rdata_q      <= rdata_d;
            wait_cnt_q   <= wait_cnt_d;
            seen_busy_q  <= seen_busy_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_wmask_q    <= s_wmask_d;
            s_rstrb_q    <= s_rstrb_d;
        end
    end

    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];
    assign m0_rbusy = pend_v_q[0] &  pend_rd_q[0];
    assign m0_wbusy = pend_v_q[0] & ~pend_rd_q[0];
    assign m1_rbusy = pend_v_q[1] &  pend_rd_q[1];
    assign m1_wbusy = pend_v_q[1] & ~pend_rd_q[1];
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wmask  = s_wmask_q;
    assign s_rstrb  = s_rstrb_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed scenarios for timing, arbitration order, forced completion and
//   mid-transaction reset, followed by a randomized two-master run checked
//   against transaction-level rules (issue matching, round-robin fairness,
//   busy-after-strobe, read data, one issue per accepted request).
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int BW = 2;
    localparam logic [31:0] IO_ADDR = 32'h0000_0FFC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [MW-1:0] m0_wmask = '0, m1_wmask = '0;
    logic          m0_rstrb = 1'b0, m1_rstrb = 1'b0;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [MW-1:0] s_wmask;
    logic          s_rstrb;
    logic [DW-1:0] slave_rdata = '0;
    logic          s_rbusy, s_wbusy;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BUSY_WAIT(BW)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
        .s_rdata(slave_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    // RAM controller model: busy for slave_lat cycles starting the cycle after a
    // request, read data loaded with busy. IO_ADDR is never serviced.
    int unsigned slave_lat = 1;
    bit          rand_lat = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_rd = '0;
    int unsigned busy_left = 0;
    logic        busy_rd = 1'b0;
    int          issue_count = 0;

    always @(posedge clk) begin
        if (busy_left > 0) busy_left <= busy_left - 1;
        if (s_rstrb || s_wmask != '0) begin
            issue_count <= issue_count + 1;
            if (s_addr != IO_ADDR) begin
                busy_left <= rand_lat ? $urandom_range(1, 3) : slave_lat;
                busy_rd   <= s_rstrb;
                if (s_rstrb) slave_rdata <= use_fixed ? fixed_rd : rd_fn(s_addr);
            end
        end
    end
    assign s_rbusy = (busy_left != 0) &&  busy_rd;
    assign s_wbusy = (busy_left != 0) && !busy_rd;

    // Reference state: last master served and expected read-data registers
    int          last_served = 1;
    logic [31:0] exp_rdata [2] = '{default: '0};

    function automatic logic get_rbusy(input int m);
        return (m == 0) ? m0_rbusy : m1_rbusy;
    endfunction
    function automatic logic get_wbusy(input int m);
        return (m == 0) ? m0_wbusy : m1_wbusy;
    endfunction
    function automatic logic [31:0] get_rdata(input int m);
        return (m == 0) ? m0_rdata : m1_rdata;
    endfunction

    task automatic drive_m(input int m, input logic rs, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] wm);
        if (m == 0) begin
            m0_rstrb = rs; m0_addr = a; m0_wdata = wd; m0_wmask = wm;
        end else begin
            m1_rstrb = rs; m1_addr = a; m1_wdata = wd; m1_wmask = wm;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single uncontended transaction, strobe in cycle 0; checks cycles 1..7
    task automatic do_txn(input int m, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, input bit extra);
        logic [31:0] exp_rd;
        int base;
        bit exp_b;
        exp_rd = exp_rdata[m];
        step();
        base = issue_count;
        drive_m(m, rd, addr, wdata, wmask);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) drive_m(m, 1'b0, '0, '0, '0);
            if (k == 2 && extra) drive_m(m, 1'b1, addr ^ 32'h100, 32'hAAAA_5555, 4'h3);
            if (k == 3) drive_m(m, 1'b0, '0, '0, '0);
            exp_b = (k <= 4);
            check($sformatf("m%0d_rbusy_c%0d", m, k), get_rbusy(m), rd & exp_b);
            check($sformatf("m%0d_wbusy_c%0d", m, k), get_wbusy(m), !rd & exp_b);
            if (k == 2) begin
                check("issue_addr", s_addr, addr);
                check("issue_rstrb", s_rstrb, rd);
                check("issue_wmask", s_wmask, rd ? 4'h0 : wmask);
                if (!rd) check("issue_wdata", s_wdata, wdata);
            end else begin
                check($sformatf("no_strobe_c%0d", k), {s_rstrb, s_wmask}, '0);
            end
            if (k == 4 && rd) exp_rd = slave_rdata;
            if (k == 5) begin
                check($sformatf("m%0d_rdata", m), get_rdata(m), exp_rd);
                check($sformatf("m%0d_other_rdata", 1 - m), get_rdata(1 - m), exp_rdata[1 - m]);
                exp_rdata[m] = exp_rd;
            end
        end
        check("one_issue", issue_count - base, 1);
        last_served = m;
    endtask

    // Both masters read in the same cycle; `first` is the predicted winner
    task automatic both_read(input int first);
        logic [31:0] a [2];
        int second;
        second = 1 - first;
        a[0] = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
        a[1] = 32'h8000_2000 + ($urandom_range(0, 255) << 2);
        step();
        drive_m(0, 1'b1, a[0], '0, '0);
        drive_m(1, 1'b1, a[1], '0, '0);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) begin
                drive_m(0, 1'b0, '0, '0, '0);
                drive_m(1, 1'b0, '0, '0, '0);
            end
            if (k == 2) begin
                check("tie_first_rstrb", s_rstrb, 1);
                check("tie_first_addr", s_addr, a[first]);
            end
            if (k == 4) check("tie_first_busy_c4", get_rbusy(first), 1);
            if (k == 5) begin
                check("tie_first_busy_c5", get_rbusy(first), 0);
                check("tie_second_busy_c5", get_rbusy(second), 1);
                check("tie_first_rdata", get_rdata(first), rd_fn(a[first]));
                exp_rdata[first] = rd_fn(a[first]);
            end
            if (k == 6) begin
                check("tie_second_rstrb", s_rstrb, 1);
                check("tie_second_addr", s_addr, a[second]);
            end
            if (k == 8) check("tie_second_busy_c8", get_rbusy(second), 1);
            if (k == 9) begin
                check("tie_second_busy_c9", get_rbusy(second), 0);
                check("tie_second_rdata", get_rdata(second), rd_fn(a[second]));
                exp_rdata[second] = rd_fn(a[second]);
            end
        end
        last_served = second;
    endtask

    // Randomized phase: per-master request bookkeeping
    typedef struct {
        bit          out;
        bit          issued;
        bit          rd;
        bit          acc_chk;
        int          acc_cyc;
        int          wait_n;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rd;
    } mst_t;

    mst_t ms [2];
    int   accepted = 0;
    int   issued_tot = 0;

    task automatic rnd_cycle(input bit allow_new);
        int g;
        logic rb, wb;
        step();
        if (s_rstrb || s_wmask != '0) begin
            g = -1;
            for (int m = 0; m < 2; m++) begin
                if (ms[m].out && !ms[m].issued && s_addr == ms[m].addr &&
                    s_rstrb == ms[m].rd && s_wmask == (ms[m].rd ? 4'h0 : ms[m].wmask) &&
                    (ms[m].rd || s_wdata == ms[m].wdata))
                    g = m;
            end
            check("rnd_issue_match", g >= 0, 1);
            if (g >= 0) begin
                ms[g].issued = 1'b1;
                issued_tot++;
                // Back-to-back issues to one master are illegal if the other was waiting
                if (g == last_served)
                    check("rnd_round_robin",
                          ms[1-g].out && !ms[1-g].issued && (ms[1-g].acc_cyc <= cyc - 2), 0);
                check("rnd_issue_latency", (cyc - ms[g].acc_cyc) >= 2, 1);
                ms[g].exp_rd = !ms[g].rd ? exp_rdata[g] :
                               (ms[g].addr == IO_ADDR) ? slave_rdata : rd_fn(ms[g].addr);
                last_served = g;
            end
        end
        for (int m = 0; m < 2; m++) begin
            rb = get_rbusy(m);
            wb = get_wbusy(m);
            if (ms[m].acc_chk) begin
                check($sformatf("rnd_m%0d_busy_on", m), {rb, wb}, ms[m].rd ? 2'b10 : 2'b01);
                ms[m].acc_chk = 1'b0;
            end else if (ms[m].out) begin
                if (!rb && !wb) begin
                    check($sformatf("rnd_m%0d_issued", m), ms[m].issued, 1);
                    check($sformatf("rnd_m%0d_rdata", m), get_rdata(m), ms[m].exp_rd);
                    exp_rdata[m] = ms[m].exp_rd;
                    ms[m].out = 1'b0;
                end else if (++ms[m].wait_n > 100) begin
                    check($sformatf("rnd_m%0d_timeout", m), 0, 1);
                    ms[m].out = 1'b0;
                end
            end
            if (allow_new && !ms[m].out && $urandom_range(0, 2) == 0) begin
                ms[m].rd    = $urandom_range(0, 1);
                ms[m].addr  = {m[0], 31'($urandom) & 31'h7FFF_FFFC};
                if (m == 0 && $urandom_range(0, 5) == 0) ms[m].addr = IO_ADDR;
                ms[m].wdata = $urandom;
                ms[m].wmask = ms[m].rd ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
                ms[m].out = 1'b1; ms[m].issued = 1'b0; ms[m].acc_chk = 1'b1;
                ms[m].acc_cyc = cyc; ms[m].wait_n = 0;
                accepted++;
                drive_m(m, ms[m].rd, ms[m].addr, ms[m].wdata, ms[m].wmask);
            end else if (allow_new && ms[m].out && $urandom_range(0, 7) == 0) begin
                drive_m(m, 1'b1, {m[0], 31'($urandom) & 31'h7FFF_FFFC}, $urandom, 4'hF);
            end else begin
                drive_m(m, 1'b0, '0, '0, '0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) step();
        check("rst_m0_rbusy", m0_rbusy, 0);
        check("rst_m1_wbusy", m1_wbusy, 0);
        check("rst_s_bus", {s_rstrb, s_wmask, s_addr}, '0);
        check("rst_rdata", m0_rdata | m1_rdata, 0);
        reset = 1'b0;

        // M0 read of 0x40 returning DEADBEEF
        use_fixed = 1'b1; fixed_rd = 32'hDEAD_BEEF;
        do_txn(0, 1'b1, 32'h40, '0, 4'h0, 1'b0);
        check("m0_deadbeef", m0_rdata, 32'hDEAD_BEEF);
        use_fixed = 1'b0;

        // M1 write, m1_rdata must stay untouched
        do_txn(1, 1'b0, 32'h80, 32'h1234_5678, 4'hF, 1'b0);

        // Simultaneous reads: winner is the master not served last
        both_read(1 - last_served);
        both_read(1 - last_served);
        do_txn(0, 1'b1, 32'h60, '0, 4'h0, 1'b0);
        both_read(1 - last_served);

        // IO address never serviced: forced completion, same timing
        do_txn(0, 1'b1, IO_ADDR, '0, 4'h0, 1'b0);

        // Second strobe during an outstanding read is ignored
        do_txn(0, 1'b1, 32'h200, '0, 4'h0, 1'b1);

        // Reset at cycle 3 of an M0 write
        step();
        drive_m(0, 1'b0, 32'h300, 32'hCAFE_F00D, 4'hF);
        step();
        drive_m(0, 1'b0, '0, '0, '0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, '0);
        check("mid_rst_s_addr", s_addr, 0);
        check("mid_rst_s_wdata", s_wdata, 0);
        check("mid_rst_s_ctl", {s_rstrb, s_wmask}, '0);
        check("mid_rst_rdata", m0_rdata | m1_rdata, 0);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        last_served = 1;
        repeat (3) step();
        do_txn(0, 1'b1, 32'h44, '0, 4'h0, 1'b0);

        // Randomized two-master traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ms[i].out = 1'b0; ms[i].issued = 1'b0; ms[i].acc_chk = 1'b0;
        end
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        for (int i = 0; i < 200 && (ms[0].out || ms[1].out || ms[0].acc_chk || ms[1].acc_chk); i++)
            rnd_cycle(1'b0);
        check("rnd_drained", ms[0].out | ms[1].out, 0);
        check("rnd_issue_count", issued_tot, accepted);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
